rifl_rx_frame_decoder: RTL

- Parametrised receive-side frame decoder for the RIFL link layer.
- Classifies each incoming frame as data, control or invalid, and checks the CRC of data frames against an expected sequence number.
- Descrambles the payload, drops replays, and decodes IDLE/PAUSE/RETRANS control codes into one-cycle pulses for the flow-control logic.
- Sits between the gearbox/aligner output and the RX FIFO.

---
 rtl/rifl_rx_frame_decoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rifl_rx_frame_decoder.sv
// RIFL RX frame decoder: classify, CRC/sequence check, descramble, replay drop, control decode.
// Define RIFL_RX_ERR_CNT_EN to add the saturating rx_error event counter (err_cnt / err_cnt_clr).
module rifl_rx_frame_decoder #(
   parameter int                   FRAME_WIDTH = 128,
   parameter int                   CRC_WIDTH   = 8,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY    = 8'h07,
   parameter int                   LOCK_FRAMES = 16,
   parameter int                   DATA_WIDTH  = FRAME_WIDTH - 4 - CRC_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef RIFL_RX_ERR_CNT_EN
   input  logic                   err_cnt_clr,
   output logic [15:0]            err_cnt,
`endif
   input  logic [FRAME_WIDTH-1:0] data_in,
   input  logic                   enable,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   valid_out,
   output logic                   crc_good,
   output logic                   rx_error,
   output logic                   ctrl_idle,
   output logic                   ctrl_pause,
   output logic                   ctrl_retrans,
   output logic                   locked
);

   localparam int                   DS_W     = 58;
   localparam logic [CRC_WIDTH-1:0] SEQ_ONE  = CRC_WIDTH'(1);
   localparam logic [CRC_WIDTH-1:0] LOCK_W   = CRC_WIDTH'(LOCK_FRAMES);
   localparam logic [3:0]           HDR_DATA = 4'b0101;
   localparam logic [3:0]           HDR_CTRL = 4'b1010;
   localparam logic [15:0]          KEY_IDLE    = 16'h9D91;
   localparam logic [15:0]          KEY_PAUSE   = 16'hD919;
   localparam logic [15:0]          KEY_RETRANS = 16'h919D;
   localparam logic [2:0]           CLS_INVALID = 3'd0;
   localparam logic [2:0]           CLS_DATA    = 3'd1;
   localparam logic [2:0]           CLS_IDLE    = 3'd2;
   localparam logic [2:0]           CLS_PAUSE   = 3'd3;
   localparam logic [2:0]           CLS_RETRANS = 3'd4;

   function automatic logic [CRC_WIDTH-1:0] crc_calc(input logic [DATA_WIDTH-1:0] d);
      logic [CRC_WIDTH-1:0] c;
      logic                 fb;
      c = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         fb = c[CRC_WIDTH-1] ^ d[i];
         c  = {c[CRC_WIDTH-2:0], 1'b0};
         if (fb) c = c ^ CRC_POLY;
      end
      return c;
   endfunction

   // stage 1
   logic                  s1_en_q, s1_en_d;
   logic [2:0]            s1_cls_q, s1_cls_d;
   logic [DATA_WIDTH-1:0] s1_pay_q, s1_pay_d;
   logic [CRC_WIDTH-1:0]  s1_crc_calc_q, s1_crc_calc_d;
   logic [CRC_WIDTH-1:0]  s1_crc_rx_q, s1_crc_rx_d;
   logic [3:0]            hdr;
   logic [15:0]           key;

   always_comb begin
      hdr      = data_in[FRAME_WIDTH-1 -: 4];
      key      = data_in[FRAME_WIDTH-7 -: 16];
      s1_cls_d = CLS_INVALID;
      if (hdr == HDR_DATA) begin
         s1_cls_d = CLS_DATA;
      end else if (hdr == HDR_CTRL) begin
         case (key)
            KEY_IDLE:    s1_cls_d = CLS_IDLE;
            KEY_PAUSE:   s1_cls_d = CLS_PAUSE;
            KEY_RETRANS: s1_cls_d = CLS_RETRANS;
            default:     s1_cls_d = CLS_INVALID;
         endcase
      end
      s1_en_d       = enable;
      s1_pay_d      = data_in[FRAME_WIDTH-5 -: DATA_WIDTH];
      s1_crc_calc_d = crc_calc(s1_pay_d);
      s1_crc_rx_d   = data_in[CRC_WIDTH-1:0];
   end

   // stage 2: link state and registered outputs
   logic [CRC_WIDTH-1:0]       seq_q, seq_d, hwm_q, hwm_d, seq_inc;
   logic [DS_W-1:0]            dstate_q, dstate_d;
   logic [DATA_WIDTH-1:0]      data_out_q, data_out_d, dsc;
   logic [DATA_WIDTH+DS_W-1:0] ext;
   logic valid_q, valid_d, good_q, good_d, rx_error_q, rx_error_d, locked_q, locked_d;
   logic idle_q, idle_d, pause_q, pause_d, retrans_q, retrans_d;
   logic is_ctrl, err_set, err_clr;

   always_comb begin
      is_ctrl = (s1_cls_q == CLS_IDLE) || (s1_cls_q == CLS_PAUSE) || (s1_cls_q == CLS_RETRANS);
      good_d  = s1_en_q && (s1_cls_q == CLS_DATA) && ((s1_crc_calc_q ^ s1_crc_rx_q) == seq_q);
      seq_inc = seq_q + SEQ_ONE;
      // bits below index 0 of this frame come from the previous good frame's top 58 bits
      ext     = {s1_pay_q, dstate_q};
      dsc     = ext[DATA_WIDTH+DS_W-1:DS_W] ^ ext[DATA_WIDTH+DS_W-40:DS_W-39] ^ ext[DATA_WIDTH-1:0];

      seq_d      = seq_q;
      hwm_d      = hwm_q;
      dstate_d   = dstate_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      if (good_d) begin
         seq_d      = seq_inc;
         dstate_d   = s1_pay_q[DATA_WIDTH-1 -: DS_W];
         data_out_d = dsc;
         if (seq_q == hwm_q) begin
            hwm_d   = hwm_q + SEQ_ONE;
            valid_d = 1'b1;
         end
      end else if (s1_en_q && !is_ctrl) begin
         seq_d = hwm_q - LOCK_W;
      end

      err_set    = s1_en_q && !good_d && !is_ctrl;
      err_clr    = good_d && (hwm_q == seq_inc);
      rx_error_d = err_set || (rx_error_q && !err_clr);
      locked_d   = locked_q || valid_d;
      idle_d     = s1_en_q && (s1_cls_q == CLS_IDLE);
      pause_d    = s1_en_q && (s1_cls_q == CLS_PAUSE);
      retrans_d  = s1_en_q && (s1_cls_q == CLS_RETRANS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_en_q       <= 1'b0;
         s1_cls_q      <= CLS_INVALID;
         s1_pay_q      <= '0;
         s1_crc_calc_q <= '0;
         s1_crc_rx_q   <= '0;
         seq_q         <= '0;
         hwm_q         <= LOCK_W;
         dstate_q      <= '0;
         data_out_q    <= '0;
         valid_q       <= 1'b0;
         good_q        <= 1'b0;
         rx_error_q    <= 1'b0;
         locked_q      <= 1'b0;
         idle_q        <= 1'b0;
         pause_q       <= 1'b0;
         retrans_q     <= 1'b0;
      end else begin
         s1_en_q       <= s1_en_d;
         s1_cls_q      <= s1_cls_d;
         s1_pay_q      <= s1_pay_d;
         s1_crc_calc_q <= s1_crc_calc_d;
         s1_crc_rx_q   <= s1_crc_rx_d;
         seq_q         <= seq_d;
         hwm_q         <= hwm_d;
         dstate_q      <= dstate_d;
         data_out_q    <= data_out_d;
         valid_q       <= valid_d;
         good_q        <= good_d;
         rx_error_q    <= rx_error_d;
         locked_q      <= locked_d;
         idle_q        <= idle_d;
         pause_q       <= pause_d;
         retrans_q     <= retrans_d;
      end
   end

`ifdef RIFL_RX_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr) begin
         err_cnt_d = '0;
      end else if (rx_error_d && !rx_error_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

   assign data_out     = data_out_q;
   assign valid_out    = valid_q;
   assign crc_good     = good_q;
   assign rx_error     = rx_error_q;
   assign ctrl_idle    = idle_q;
   assign ctrl_pause   = pause_q;
   assign ctrl_retrans = retrans_q;
   assign locked       = locked_q;

endmodule
